// File: rtl/dso_spi_pkg.sv
// Shared definitions for the calibration-EEPROM SPI responder.
//  FRAME_W  : bits per SPI frame
//  OP_*     : opcode values carried in cmd[15:14]
//  state_e  : frame-handling FSM states
package dso_spi_pkg;

  localparam int FRAME_W = 16;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    EXEC
  } state_e;

endpackage

// File: rtl/eep_spi_slave_if.sv
// SPI pin bundle between the DSO SPI master and the EEPROM responder.
//  SCLK : SPI clock, mode 0 (idle low)
//  SS_n : active-low slave select
//  MOSI : master-to-slave data, MSB first
//  MISO : slave-to-master data, MSB first
interface eep_spi_slave_if;

  logic SCLK;
  logic SS_n;
  logic MOSI;
  logic MISO;

  modport master (output SCLK, output SS_n, output MOSI, input MISO);
  modport slave  (input SCLK, input SS_n, input MOSI, output MISO);

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with edge pulses.
//  clk, rst : system clock, synchronous active-high reset
//  d        : asynchronous input
//  q        : synchronized level (last stage)
//  rise     : 1-cycle pulse, 0->1 seen between the last two stages
//  fall     : 1-cycle pulse, 1->0 seen between the last two stages
module spi_sync_edge #(
  parameter int   STAGES  = 3,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise =  sync_q[STAGES-2] & ~sync_q[STAGES-1];
  assign fall = ~sync_q[STAGES-2] &  sync_q[STAGES-1];

endmodule

// File: rtl/eep_spi_slave.sv
// SPI slave model of the calibration EEPROM (64x8 byte store).
// Each 16-bit frame is {op[1:0], addr[5:0], wdata[7:0]}; READ data is
// returned in the low byte of the following frame.
//  clk, rst : system clock (>= 8x SCLK), synchronous active-high reset
//  spi      : SCLK/SS_n/MOSI in, MISO out (slave modport)
//  cmd      : last complete frame received
//  cmd_rdy  : 1-cycle pulse, cmd valid and command executed
//  frm_err  : 1-cycle pulse, SS_n rose with a bit count other than FRAME_W
module eep_spi_slave
  import dso_spi_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int SYNC_FF = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  eep_spi_slave_if.slave       spi,
  output logic [FRAME_W-1:0]   cmd,
  output logic                 cmd_rdy,
  output logic                 frm_err
);

  localparam int FLUSH_W = $clog2(SYNC_FF + 1);

  // Synchronized pins and edge pulses
  logic sclk_sync_unused, sclk_rise, sclk_fall;
  logic ss_sync, ss_rise, ss_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_FF), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(spi.SCLK),
    .q(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_FF), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst(rst), .d(spi.SS_n),
    .q(ss_sync), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_FF), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(spi.MOSI),
    .q(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  // Byte store, not reset
  logic [7:0] mem [0:2**ADDR_W-1];

  state_e             state_q,   state_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0] rx_q,      rx_d;
  logic [FRAME_W-1:0] tx_q,      tx_d;
  logic [FRAME_W-1:0] cmd_q,     cmd_d;
  logic               cmd_rdy_q, cmd_rdy_d;
  logic               frm_err_q, frm_err_d;
  logic               miso_q,    miso_d;
  logic [7:0]         rd_byte_q;
  logic [FLUSH_W-1:0] flush_q,   flush_d;
  logic               armed_q,   armed_d;

  logic [1:0]         exec_op;
  logic [ADDR_W-1:0]  exec_addr;
  logic               flush_done;

  assign exec_op   = rx_q[15:14];
  assign exec_addr = rx_q[8 +: ADDR_W];

  // The SS_n synchronizer resets to 1, so a reset taken while SS_n is held
  // low would otherwise look like a fresh ss_fall and start a bogus frame.
  // New frames are only accepted once the chain has flushed and SS_n has
  // genuinely been seen high.
  assign flush_done = (flush_q == FLUSH_W'(SYNC_FF));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = 1'b0;
    frm_err_d = 1'b0;
    flush_d   = flush_done ? flush_q : flush_q + 1'b1;
    armed_d   = armed_q | (flush_done & ss_sync);

    unique case (state_q)
      IDLE: begin
        if (ss_fall && armed_q) begin
          tx_d      = {8'h00, rd_byte_q};
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // End of frame wins over any SCLK edge seen in the same cycle
        if (ss_rise) begin
          if (bit_cnt_q == 5'(FRAME_W)) begin
            state_d = EXEC;
          end else begin
            frm_err_d = 1'b1;
            state_d   = IDLE;
          end
        end else begin
          if (sclk_rise) begin
            rx_d = {rx_q[FRAME_W-2:0], mosi_sync};
            if (bit_cnt_q != 5'd31) begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
          if (sclk_fall) begin
            tx_d = {tx_q[FRAME_W-2:0], 1'b0};
          end
        end
      end
      EXEC: begin
        cmd_d     = rx_q;
        cmd_rdy_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    miso_d = (state_d == SHIFT) ? tx_d[FRAME_W-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
      frm_err_q <= 1'b0;
      miso_q    <= 1'b0;
      flush_q   <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
      frm_err_q <= frm_err_d;
      miso_q    <= miso_d;
      flush_q   <= flush_d;
      armed_q   <= armed_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == EXEC && exec_op == OP_WRITE) begin
      mem[exec_addr] <= rx_q[7:0];
    end
  end

  // Registered read port; only updated by a READ in EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_byte_q <= 8'h00;
    end else if (state_q == EXEC && exec_op == OP_READ) begin
      rd_byte_q <= mem[exec_addr];
    end
  end

  assign spi.MISO = miso_q;
  assign cmd      = cmd_q;
  assign cmd_rdy  = cmd_rdy_q;
  assign frm_err  = frm_err_q;

endmodule

// File: tb/tb_eep_spi_slave.sv
// Directed testbench for eep_spi_slave: drives SPI mode-0 frames, keeps a
// byte-level model of the EEPROM and compares pulses, cmd and MISO data.
module tb_eep_spi_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        frm_err;

  eep_spi_slave_if spi();

  eep_spi_slave dut (
    .clk     (clk),
    .rst     (rst),
    .spi     (spi.slave),
    .cmd     (cmd),
    .cmd_rdy (cmd_rdy),
    .frm_err (frm_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Observed pulse counters maintained by the compare process
  int rdy_cnt = 0;
  int err_cnt = 0;

  // Behavioural model of the EEPROM
  logic [7:0]  model_mem [0:63];
  logic [7:0]  model_rd = 8'h00;
  logic [15:0] exp_cmd  = 16'h0000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_exec(input logic [15:0] w);
    case (w[15:14])
      2'b00:   model_rd = model_mem[w[13:8]];
      2'b01:   model_mem[w[13:8]] = w[7:0];
      default: ;
    endcase
  endtask

  // One frame: SCLK half-period = 8 clk, SS_n high gap = one SCLK period.
  // rst_at >= 0 pulses rst just before bit rst_at is driven.
  task automatic send_frame(input logic [15:0] w, input int nbits, input int rst_at,
                            output logic [15:0] miso_w);
    logic [7:0] rd_before;
    int r0, e0;
    rd_before = model_rd;
    r0 = rdy_cnt;
    e0 = err_cnt;
    exp_cmd = w;
    miso_w = 16'h0000;
    spi.SS_n = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        model_rd = 8'h00;
      end
      spi.MOSI = w[15-i];
      wait_clk(8);
      miso_w[15-i] = spi.MISO;
      spi.SCLK = 1'b1;
      wait_clk(8);
      spi.SCLK = 1'b0;
    end
    wait_clk(8);
    spi.SS_n = 1'b1;
    wait_clk(16);
    if (rst_at >= 0) begin
      chk("rst_frame_rdy", rdy_cnt - r0, 0);
      chk("rst_frame_err", err_cnt - e0, 0);
    end else if (nbits == 16) begin
      chk("frame_rdy", rdy_cnt - r0, 1);
      chk("frame_err", err_cnt - e0, 0);
      chk("miso_word", {16'h0, miso_w}, {24'h0, rd_before});
      model_exec(w);
    end else begin
      chk("short_rdy", rdy_cnt - r0, 0);
      chk("short_err", err_cnt - e0, 1);
    end
    $display("frame w=%h bits=%0d rst_at=%0d miso=%h cmd=%h model_rd=%h",
             w, nbits, rst_at, miso_w, cmd, model_rd);
  endtask

  // Compare process: pulse widths, cmd on every cmd_rdy, MISO idle low
  initial begin
    logic rdy_prev, err_prev;
    int ss_high_cyc;
    rdy_prev = 1'b0;
    err_prev = 1'b0;
    ss_high_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rdy_prev = 1'b0;
        err_prev = 1'b0;
      end else begin
        if (cmd_rdy) begin
          rdy_cnt++;
          chk("cmd_on_rdy", {16'h0, cmd}, {16'h0, exp_cmd});
          chk("rdy_width", {31'h0, rdy_prev}, 0);
          chk("rdy_err_excl", {31'h0, frm_err}, 0);
        end
        if (frm_err) begin
          err_cnt++;
          chk("err_width", {31'h0, err_prev}, 0);
        end
        if (ss_high_cyc >= 6) begin
          chk("miso_idle", {31'h0, spi.MISO}, 0);
        end
        rdy_prev = cmd_rdy;
        err_prev = frm_err;
      end
      ss_high_cyc = (spi.SS_n === 1'b1) ? ss_high_cyc + 1 : 0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] mw;
    rst = 1'b1;
    spi.SS_n = 1'b1;
    spi.SCLK = 1'b0;
    spi.MOSI = 1'b0;

    // 1: reset state
    wait_clk(2);
    chk("rst_miso",    {31'h0, spi.MISO}, 0);
    chk("rst_cmd",     {16'h0, cmd}, 0);
    chk("rst_cmd_rdy", {31'h0, cmd_rdy}, 0);
    chk("rst_frm_err", {31'h0, frm_err}, 0);
    rst = 1'b0;
    wait_clk(10);

    // 2: write then read back
    send_frame(16'h4A5C, 16, -1, mw);
    chk("t2_cmd_lit", {16'h0, cmd}, 32'h4A5C);
    send_frame(16'h0A00, 16, -1, mw);
    send_frame(16'hC000, 16, -1, mw);
    chk("t2_miso_lit", {16'h0, mw}, 32'h005C);

    // 3: short frame leaves the store alone
    send_frame(16'h4A11, 12, -1, mw);
    send_frame(16'h4266, 16, -1, mw);
    send_frame(16'h0200, 16, -1, mw);
    send_frame(16'h0A00, 16, -1, mw);
    chk("t3_miso_02_lit", {16'h0, mw}, 32'h0066);
    send_frame(16'hC000, 16, -1, mw);
    chk("t3_miso_0a_lit", {16'h0, mw}, 32'h005C);

    // 4: reset mid-frame, then normal decode (rd_byte back to 0)
    send_frame(16'h4233, 16, 8, mw);
    send_frame(16'h4533, 16, -1, mw);
    chk("t4_miso_lit", {16'h0, mw}, 32'h0000);
    chk("t4_cmd_lit", {16'h0, cmd}, 32'h4533);
    send_frame(16'h0500, 16, -1, mw);
    send_frame(16'hC000, 16, -1, mw);
    chk("t4_rd_lit", {16'h0, mw}, 32'h0033);

    // 5: back-to-back frames at the top address
    send_frame(16'h7FA5, 16, -1, mw);
    send_frame(16'h3F00, 16, -1, mw);
    send_frame(16'hC000, 16, -1, mw);
    chk("t5_miso_lit", {16'h0, mw}, 32'h00A5);

    // 6: unknown opcode changes neither store nor rd_byte
    send_frame(16'h4177, 16, -1, mw);
    send_frame(16'h8123, 16, -1, mw);
    chk("t6_cmd_lit", {16'h0, cmd}, 32'h8123);
    send_frame(16'h0100, 16, -1, mw);
    chk("t6_rd_kept_lit", {16'h0, mw}, 32'h00A5);
    send_frame(16'hC000, 16, -1, mw);
    chk("t6_store_lit", {16'h0, mw}, 32'h0077);
    chk("model_pin", {24'h0, model_rd}, 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
